// File: rtl/lfsr_prng_stream_if.sv
// lfsr_prng_stream_if
//   Stream channel carrying pseudo-random words from the generator to its consumer.
//   Signals:
//     m_tvalid  producer -> consumer  word valid
//     m_tready  consumer -> producer  consumer ready
//     m_tdata   producer -> consumer  random word, WIDTH bits
//   Modports: master (generator side), slave (consumer side).
`timescale 1ns/1ps
interface lfsr_prng_stream_if #(
   parameter int WIDTH = 32
) ();
   logic             m_tvalid;
   logic             m_tready;
   logic [WIDTH-1:0] m_tdata;

   modport master (
      output m_tvalid,
      output m_tdata,
      input  m_tready
   );

   modport slave (
      input  m_tvalid,
      input  m_tdata,
      output m_tready
   );
endinterface

// File: rtl/lfsr_prng_stream.sv
// lfsr_prng_stream
//   Fibonacci-LFSR pseudo-random word generator with a valid/ready output stage.
//   Each output word is the LFSR state after STEPS shifts; the word counter
//   tracks words produced since reset or the last seed load.
//   Ports:
//     ACLK        in   clock, rising edge
//     ARESETn     in   asynchronous active-low reset
//     enable      in   1 = generate words, 0 = paused
//     seed_load   in   one-cycle strobe, load seed_value (highest priority)
//     seed_value  in   runtime seed, WIDTH bits
//     m_axis      master modport of lfsr_prng_stream_if (m_tvalid/m_tready/m_tdata)
//     word_count  out  words produced, wraps mod 2^CNT_W
//     lockup      out  one-cycle pulse: zero seed rejected, SEED substituted
`timescale 1ns/1ps
module lfsr_prng_stream #(
   parameter int               WIDTH = 32,
   parameter logic [WIDTH-1:0] TAPS  = 32'h80200003,
   parameter logic [WIDTH-1:0] SEED  = 32'h0000ACE1,
   parameter int               STEPS = 1,
   parameter int               CNT_W = 32
) (
   input  logic                ACLK,
   input  logic                ARESETn,
   input  logic                enable,
   input  logic                seed_load,
   input  logic [WIDTH-1:0]    seed_value,
   lfsr_prng_stream_if.master  m_axis,
   output logic [CNT_W-1:0]    word_count,
   output logic                lockup
);

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   // Reject parameter sets that cannot produce a usable sequence.
   if (WIDTH < 3 || WIDTH > 64) begin : g_bad_width
      $error("lfsr_prng_stream: WIDTH must be in 3..64");
   end
   if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
      $error("lfsr_prng_stream: STEPS must be in 1..WIDTH");
   end
   if (SEED == {WIDTH{1'b0}}) begin : g_bad_seed
      $error("lfsr_prng_stream: SEED must be nonzero");
   end
   if (TAPS == {WIDTH{1'b0}}) begin : g_bad_taps
      $error("lfsr_prng_stream: TAPS must be nonzero");
   end

   // STEPS shifts unrolled into one combinational cone.
   function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] cur);
      logic [WIDTH-1:0] v;
      v = cur;
      for (int i = 0; i < STEPS; i++) begin
         v = {v[WIDTH-2:0], ^(v & TAPS)};
      end
      return v;
   endfunction

   logic [WIDTH-1:0] state_r;
   logic [WIDTH-1:0] state_d_s;
   logic [WIDTH-1:0] tdata_r;
   logic [WIDTH-1:0] tdata_d_s;
   logic [0:0]       fsm_r;
   logic [0:0]       fsm_d_s;
   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] count_d_s;
   logic             lockup_r;
   logic             lockup_d_s;
   logic [WIDTH-1:0] stepped_s;
   logic [WIDTH-1:0] next_s;
   logic             advance_s;

   // Next-state logic: seed load beats advance, advance beats drain/hold.
   always_comb begin
      stepped_s  = lfsr_next(state_r);
      // Tap masks without the MSB set can shift a nonzero state into all-zero;
      // fall back to SEED so the generator never locks up.
      if (stepped_s == {WIDTH{1'b0}}) begin
         next_s = SEED;
      end else begin
         next_s = stepped_s;
      end
      advance_s  = enable && ((fsm_r == ST_EMPTY) || m_axis.m_tready);
      state_d_s  = state_r;
      tdata_d_s  = tdata_r;
      fsm_d_s    = fsm_r;
      count_d_s  = count_r;
      lockup_d_s = 1'b0;
      if (seed_load) begin
         fsm_d_s   = ST_EMPTY;
         count_d_s = {CNT_W{1'b0}};
         if (seed_value == {WIDTH{1'b0}}) begin
            state_d_s  = SEED;
            lockup_d_s = 1'b1;
         end else begin
            state_d_s  = seed_value;
         end
      end else if (advance_s) begin
         state_d_s = next_s;
         tdata_d_s = next_s;
         fsm_d_s   = ST_FULL;
         count_d_s = count_r + CNT_W'(1);
      end else begin
         // Not advancing while FULL and ready means enable is low: drain.
         case (fsm_r)
            ST_FULL: begin
               if (m_axis.m_tready) begin
                  fsm_d_s = ST_EMPTY;
               end else begin
                  fsm_d_s = ST_FULL;
               end
            end
            ST_EMPTY: fsm_d_s = ST_EMPTY;
            default:  fsm_d_s = ST_EMPTY;
         endcase
      end
   end

   // State, output and counter registers with asynchronous reset.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_r  <= SEED;
         tdata_r  <= {WIDTH{1'b0}};
         fsm_r    <= ST_EMPTY;
         count_r  <= {CNT_W{1'b0}};
         lockup_r <= 1'b0;
      end else begin
         state_r  <= state_d_s;
         tdata_r  <= tdata_d_s;
         fsm_r    <= fsm_d_s;
         count_r  <= count_d_s;
         lockup_r <= lockup_d_s;
      end
   end

   assign m_axis.m_tvalid = (fsm_r == ST_FULL);
   assign m_axis.m_tdata  = tdata_r;
   assign word_count      = count_r;
   assign lockup          = lockup_r;

endmodule

// File: tb/tb_lfsr_prng_stream.sv
`timescale 1ns/1ps
module tb_lfsr_prng_stream;
   logic        ACLK;
   logic        ARESETn;
   logic        enable;
   logic        seed_load;
   logic [31:0] seed_value;
   logic [3:0]  wc;
   logic        lockup;
   logic        e8;
   logic [15:0] wc8;
   logic [15:0] wc8s;
   logic        lk8;
   logic        lk8s;

   int tests_run    = 0;
   int tests_failed = 0;

   lfsr_prng_stream_if #(.WIDTH(32)) ax   ();
   lfsr_prng_stream_if #(.WIDTH(8))  ax8  ();
   lfsr_prng_stream_if #(.WIDTH(8))  ax8s ();

   lfsr_prng_stream #(.WIDTH(32), .TAPS(32'h80200003), .SEED(32'h0000ACE1), .STEPS(1), .CNT_W(4)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn), .enable(enable), .seed_load(seed_load),
      .seed_value(seed_value), .m_axis(ax), .word_count(wc), .lockup(lockup));

   lfsr_prng_stream #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .STEPS(1), .CNT_W(16)) dut8 (
      .ACLK(ACLK), .ARESETn(ARESETn), .enable(e8), .seed_load(1'b0),
      .seed_value(8'h00), .m_axis(ax8), .word_count(wc8), .lockup(lk8));

   lfsr_prng_stream #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .STEPS(8), .CNT_W(16)) dut8s (
      .ACLK(ACLK), .ARESETn(ARESETn), .enable(e8), .seed_load(1'b0),
      .seed_value(8'h00), .m_axis(ax8s), .word_count(wc8s), .lockup(lk8s));

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   // Reference shifts written out tap by tap.
   function automatic logic [31:0] m32(input logic [31:0] s);
      return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
   endfunction

   function automatic logic [7:0] m8(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [31:0] exp32;
      logic [7:0]  exp8;
      logic [7:0]  exp8s;
      int          zero_seen;
      int          early_repeat;

      ARESETn     = 1'b0;
      enable      = 1'b0;
      seed_load   = 1'b0;
      seed_value  = 32'h0;
      e8          = 1'b0;
      ax.m_tready   = 1'b0;
      ax8.m_tready  = 1'b1;
      ax8s.m_tready = 1'b1;
      tick();
      tick();
      check("rst_tvalid", 64'(ax.m_tvalid), 64'h0);
      check("rst_tdata",  64'(ax.m_tdata),  64'h0);
      check("rst_count",  64'(wc),          64'h0);
      check("rst_lockup", 64'(lockup),      64'h0);
      ARESETn = 1'b1;
      tick();
      check("idle_tvalid", 64'(ax.m_tvalid), 64'h0);

      // First three words after enable.
      enable      = 1'b1;
      ax.m_tready = 1'b1;
      tick();
      check("w1_valid", 64'(ax.m_tvalid), 64'h1);
      check("w1_data",  64'(ax.m_tdata),  64'h000159C3);
      check("w1_count", 64'(wc),          64'h1);
      tick();
      check("w2_data",  64'(ax.m_tdata),  64'h0002B386);
      tick();
      check("w3_data",  64'(ax.m_tdata),  64'h0005670D);
      check("w3_count", 64'(wc),          64'h3);

      // Backpressure: word and count frozen, then resume with no gap.
      ax.m_tready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_data",  64'(ax.m_tdata),  64'h0005670D);
         check("bp_count", 64'(wc),          64'h3);
         check("bp_valid", 64'(ax.m_tvalid), 64'h1);
      end
      ax.m_tready = 1'b1;
      tick();
      check("bp_resume_data",  64'(ax.m_tdata), 64'h000ACE1B);
      check("bp_resume_count", 64'(wc),         64'h4);

      // Runtime reseed with 1 while FULL.
      seed_load  = 1'b1;
      seed_value = 32'h00000001;
      tick();
      seed_load  = 1'b0;
      check("ld1_valid",  64'(ax.m_tvalid), 64'h0);
      check("ld1_count",  64'(wc),          64'h0);
      check("ld1_lockup", 64'(lockup),      64'h0);
      tick();
      check("ld1_w1_valid", 64'(ax.m_tvalid), 64'h1);
      check("ld1_w1_data",  64'(ax.m_tdata),  64'h00000003);
      check("ld1_w1_count", 64'(wc),          64'h1);
      tick();
      check("ld1_w2_data",  64'(ax.m_tdata),  64'h00000006);

      // Zero seed: lockup pulse and SEED substituted.
      seed_load  = 1'b1;
      seed_value = 32'h00000000;
      tick();
      seed_load  = 1'b0;
      check("ld0_lockup", 64'(lockup),      64'h1);
      check("ld0_valid",  64'(ax.m_tvalid), 64'h0);
      check("ld0_count",  64'(wc),          64'h0);
      tick();
      check("ld0_lockup_off", 64'(lockup),     64'h0);
      check("ld0_w1_data",    64'(ax.m_tdata), 64'h000159C3);
      check("ld0_w1_count",   64'(wc),         64'h1);

      // enable low: pending word held until accepted, then drained; state paused.
      ax.m_tready = 1'b0;
      enable      = 1'b0;
      tick();
      check("en0_hold_valid", 64'(ax.m_tvalid), 64'h1);
      check("en0_hold_data",  64'(ax.m_tdata),  64'h000159C3);
      ax.m_tready = 1'b1;
      tick();
      check("en0_drain_valid", 64'(ax.m_tvalid), 64'h0);
      check("en0_drain_count", 64'(wc),          64'h1);
      enable = 1'b1;
      tick();
      check("en1_data",  64'(ax.m_tdata), 64'h0002B386);
      check("en1_count", 64'(wc),         64'h2);
      tick();
      tick();

      // Asynchronous reset mid-stream, then 17 words wrap the 4-bit counter to 1.
      ARESETn = 1'b0;
      #2;
      check("arst_valid", 64'(ax.m_tvalid), 64'h0);
      check("arst_data",  64'(ax.m_tdata),  64'h0);
      check("arst_count", 64'(wc),          64'h0);
      #1;
      ARESETn = 1'b1;
      tick();
      check("arst_w1_data",  64'(ax.m_tdata), 64'h000159C3);
      check("arst_w1_count", 64'(wc),         64'h1);
      exp32 = 32'h000159C3;
      for (int n = 2; n <= 17; n++) begin
         tick();
         exp32 = m32(exp32);
         check("stream_data", 64'(ax.m_tdata), 64'(exp32));
         if (n == 16) check("wrap16_count", 64'(wc), 64'h0);
      end
      check("w17_count", 64'(wc), 64'h1);
      enable = 1'b0;

      // 8-bit maximal-length LFSR: period 255, never zero; STEPS=8 matches 8k-th step.
      e8           = 1'b1;
      exp8         = 8'h01;
      exp8s        = 8'h01;
      zero_seen    = 0;
      early_repeat = 0;
      for (int n = 1; n <= 255; n++) begin
         tick();
         exp8 = m8(exp8);
         for (int j = 0; j < 8; j++) exp8s = m8(exp8s);
         if (n == 1) begin
            check("w8_first",  64'(ax8.m_tdata),  64'h02);
            check("w8s_first", 64'(ax8s.m_tdata), 64'h1C);
         end
         check("w8_model",  64'(ax8.m_tdata),  64'(exp8));
         check("w8s_model", 64'(ax8s.m_tdata), 64'(exp8s));
         if (ax8.m_tdata == 8'h00) zero_seen++;
         if (ax8.m_tdata == 8'h01 && n < 255) early_repeat++;
      end
      check("w8_period_end", 64'(ax8.m_tdata), 64'h01);
      check("w8_zero_seen",  64'(zero_seen),   64'h0);
      check("w8_early_rep",  64'(early_repeat), 64'h0);
      check("w8_count",      64'(wc8),         64'd255);
      e8 = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
